// File: rtl/bus_pkg.sv
// Shared definitions for the round-robin shared bus:
// arbiter state encoding, owner width and rotation search helpers.
package bus_pkg;

   localparam int unsigned MAX_M = 32;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_t;

   function automatic int unsigned ow_width(input int unsigned m);
      return (m > 1) ? $clog2(m) : 1;
   endfunction

   // First set bit of r at or after 'from', wrapping within m bits.
   function automatic int unsigned rr_first(
      input logic [MAX_M-1:0] r,
      input int unsigned      from,
      input int unsigned      m
   );
      int unsigned idx;
      int unsigned pick;
      logic        found;
      pick  = 0;
      found = 1'b0;
      for (int unsigned k = 0; k < MAX_M; k++) begin
         if (k < m) begin
            idx = from + k;
            if (idx >= m) idx = idx - m;
            if (!found && r[idx[4:0]]) begin
               pick  = idx;
               found = 1'b1;
            end
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a bounded hold time while others wait.
// Grant and owner are registered; handover is edge-to-edge.
module rr_arbiter
   import bus_pkg::*;
#(
   parameter int unsigned M        = 4,
   parameter int unsigned MAX_HOLD = 4,
   localparam int unsigned OW      = ow_width(M)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [M-1:0]  req,
   output logic [M-1:0]  gnt,
   output logic [OW-1:0] owner
);

   localparam int unsigned HW = $clog2(MAX_HOLD + 1);

   arb_state_t    state_q, state_d;
   logic [M-1:0]  gnt_q, gnt_d;
   logic [OW-1:0] owner_q, owner_d;
   logic [OW-1:0] ptr_q, ptr_d;
   logic [HW-1:0] hold_q, hold_d;

   logic [MAX_M-1:0] req_x;
   logic [MAX_M-1:0] oth_x;
   logic [M-1:0]     oth;
   logic             take;
   logic             at_max;
   int unsigned      pick;

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      hold_d  = hold_q;
      take    = 1'b0;
      pick    = 0;
      oth     = req & ~gnt_q;
      req_x   = '0;
      req_x[M-1:0] = req;
      oth_x   = '0;
      oth_x[M-1:0] = oth;
      at_max  = (hold_q >= HW'(MAX_HOLD));

      unique case (state_q)
         ST_IDLE: begin
            if (|req) begin
               take = 1'b1;
               pick = rr_first(req_x, 32'(ptr_q), M);
            end
         end
         ST_BUSY: begin
            if (req[owner_q] && (!at_max || !(|oth))) begin
               if (!at_max) hold_d = hold_q + 1'b1;
            end else if (|oth) begin
               // ptr already points one past the owner
               take = 1'b1;
               pick = rr_first(oth_x, 32'(ptr_q), M);
            end else begin
               state_d = ST_IDLE;
               gnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
         end
      endcase

      if (take) begin
         state_d = ST_BUSY;
         for (int unsigned i = 0; i < M; i++) begin
            gnt_d[i] = (pick == i);
         end
         owner_d = OW'(pick);
         hold_d  = HW'(1);
         ptr_d   = (pick >= M - 1) ? '0 : OW'(pick + 1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         owner_q <= '0;
         ptr_q   <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
      end
   end

   assign gnt   = gnt_q;
   assign owner = owner_q;

endmodule

// File: rtl/shared_bus_rr.sv
// Multi-master tri-state shared bus with round-robin ownership
// and a registered bus copy common to all masters.
module shared_bus_rr
   import bus_pkg::*;
#(
   parameter int unsigned W        = 8,
   parameter int unsigned M        = 4,
   parameter int unsigned MAX_HOLD = 4,
   localparam int unsigned OW      = ow_width(M)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [M-1:0]   req,
   input  logic [M*W-1:0] data_in,
   output logic [M-1:0]   gnt,
   output logic [OW-1:0]  owner,
   output logic [W-1:0]   data_out,
   output logic           data_valid
);

   tri [W-1:0] bus_data;

   rr_arbiter #(
      .M        (M),
      .MAX_HOLD (MAX_HOLD)
   ) u_arb (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .gnt   (gnt),
      .owner (owner)
   );

   // One-hot grant guarantees a single enabled driver.
   for (genvar i = 0; i < M; i++) begin : g_drv
      assign bus_data = gnt[i] ? data_in[i*W +: W] : {W{1'bz}};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_out   <= '0;
         data_valid <= 1'b0;
      end else if (|gnt) begin
         data_out   <= bus_data;
         data_valid <= 1'b1;
      end else begin
         data_valid <= 1'b0;
      end
   end

endmodule

// File: doc/shared_bus_rr.md
# shared_bus_rr

Parametrised multi-master shared bus: M requesters contend for one W-bit tri-stated bus. A round-robin arbiter with a bounded hold time picks the owner. Only the granted master's tri-state driver is enabled, and every master sees the same registered copy of the bus. It supersedes the fixed two-device tri-state bus. It is the interconnect between peripheral data sources and their consumers in the datapath.

## Interface
- W, 8, data width in bits
- M, 4, number of masters (≥1)
- MAX_HOLD, 4, max consecutive cycles one master may own the bus while others are waiting
- OW, (M>1 ? $clog2(M) : 1), owner index width (localparam)

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  M  per-master request; level-sensitive, sampled every edge
- data_in  in  M*W  master i data at [i*W +: W]
- gnt  out  M  registered one-hot grant; all-zero when idle
- owner  out  OW  index of current owner; holds last value when idle
- data_out  out  W  registered bus value, common to all masters
- data_valid  out  1  data_out was captured from a driven bus

## Operation
- Internal bus bus_data (W-bit tri-state net).
  - Master i drives bus_data = data_in[i] when gnt[i]=1; otherwise it drives Z.
  - At most one driver is enabled at any time.
- Arbiter states:
  - IDLE: gnt=0.
  - BUSY: exactly one gnt bit set.
  - hold_cnt counts owner cycles (1..MAX_HOLD).
  - Rotation pointer ptr = (owner+1) mod M.
- IDLE:
  - If req≠0, grant the first set req bit scanning from ptr upward with wrap; set hold_cnt=1 and go to BUSY.
  - Otherwise stay in IDLE.
- BUSY, owner o:
  - Others waiting = (req with bit o masked) ≠ 0.
  - req[o]=1 and (hold_cnt<MAX_HOLD or no others waiting): keep o; hold_cnt = min(hold_cnt+1, MAX_HOLD).
  - Otherwise, if others are waiting: grant the next requester scanning from o+1 with wrap; hold_cnt=1. The new gnt replaces the old on the same edge, with no idle cycle between them.
  - Otherwise, go to IDLE with gnt=0; owner keeps o.
- Capture:
  - Each edge with gnt≠0: data_out ← bus_data, data_valid ← 1.
  - Each edge with gnt=0: data_out holds, data_valid ← 0.
- M=1: the grant is simply a registered req[0]. The hold limit never forces release because no other master can be waiting.

## Timing
- Reset, synchronous: gnt=0, owner=0, data_out=0, data_valid=0, hold_cnt=0, ptr=0, state IDLE.
  - Master 0 therefore has first priority after reset.
  - Reset asserted mid-grant releases the bus at that edge.
- Latency, req to gnt: req high before edge E gives gnt high after E.
- Latency, to data: data_out and data_valid are valid after E+1 and carry the data_in value present in the cycle between E and E+1.
- Handover: the old owner's last bus cycle and the new owner's first cycle are adjacent, so data_valid stays high across the switch.
- Dropping req: the release takes effect at the next edge. data_valid stays high for one more edge, then falls.
- Simultaneous requests: resolved purely by rotation from ptr. No fixed priority exists except immediately after reset.
- Starvation bound: a continuously requesting master is granted within (M−1)·MAX_HOLD cycles.

## Structure
- Shared package bus_pkg:
  - arbiter state encoding (IDLE, BUSY)
  - OW width function
  - round-robin "first set bit from index" function
- Sub-module rr_arbiter #(M, MAX_HOLD):
  - inputs clk, rst, req
  - outputs gnt, owner
  - contains the state, hold_cnt and ptr registers
- Top level: generate loop of M tri-state drivers onto bus_data, plus the data_out / data_valid capture register.

## Test plan
Parameters W=8, M=4, MAX_HOLD=4.
- **Reset and single request:** after reset, data_in0=AA and req=0001 → gnt=0001 one edge later; data_out=AA with data_valid=1 on the following edge; no X on bus_data.
- **Simultaneous requests after reset:** data_in0=AA, data_in2=55, req=0101 held → master 0 owns for 4 cycles, then master 2 for 4 cycles. data_out sequence is AA×4, then 55×4, with no data_valid gap at the handover.
- **Rotation with early release:** req=1111 with each master dropping req after its 2nd cycle → grant order 0,1,2,3,0; each master owns exactly 2 cycles.
- **Lone requester:** req=0010 for 10 cycles → gnt stays 0010 for all 10 cycles, hold_cnt saturates at 4, with no forced release.
- **Idle after release:** req falls to 0000 → gnt=0 next edge; data_valid drops one edge later; data_out holds its last value; owner keeps its last index.
- **Reset mid-grant:** rst pulsed while gnt=0100 → all outputs return to reset values at that edge. With req=1111 afterwards, master 0 is granted first.
